// File: rtl/iter_multdiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, sign-fixed in a final cycle.
module iter_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_signed;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_sh, div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Both ops keep the magnitude of 'a' in the low half of acc; 'b' is the
  // multiplicand or divisor held in opb.
  always_comb begin
    is_signed = ~op[0];
    a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ok   = ~div_diff[WIDTH];
    div_step = {(div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};

    // Two's-complement negation of the magnitude also yields MIN/-1 -> MIN.
    prod_fix = qneg_q ? -acc_q : acc_q;
    quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          opb_d    = b_abs;
          acc_d    = {{WIDTH{1'b0}}, a_abs};
          qneg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = is_signed & a[WIDTH-1];
          cnt_d    = CNT_W'(WIDTH);
          dz_d     = op[1] && (b == '0);
          state_d  = (op[1] && (b == '0)) ? S_DONE : S_CALC;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        acc_d = is_div_q ? div_step : mul_step;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = done & dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
